sfp_ctrl: RTL and testbench

- Sequences one output-tile computation through the special-function/accumulator stage (SFP) that sits below the last MAC-array row.
- Per column, gates MAC psum valids so each column receives exactly one psum per accumulation pass, for a programmed number of passes (e.g. 9 for a 3x3 kernel).
- Then drains the activated accumulators to the output FIFO in a single write and clears them.
- Latches and holds the SFP activation configuration (relu_en, lrelu_en, shift) for the whole operation.

---
 rtl/sfp_ctrl.sv | 91 +++++++++
 tb/tb_sfp_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sfp_ctrl.sv
// Sequences one output tile through the SFP stage: gates MAC psums into the
// accumulators pass by pass, then drains them to the output FIFO and clears them.
module sfp_ctrl #(
  parameter int col     = 8,
  parameter int pass_bw = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [pass_bw-1:0] num_pass,
  input  logic [1:0]         act_mode,
  input  logic [1:0]         act_shift,
  input  logic [col-1:0]     mac_valid,
  input  logic               ofifo_full,
  output logic [col-1:0]     sfp_valid_in,
  output logic               acc_clr,
  output logic [col-1:0]     ofifo_wr,
  output logic               relu_en,
  output logic               lrelu_en,
  output logic [1:0]         shift,
  output logic               busy,
  output logic               done,
  output logic               dup_err
);

  typedef enum logic [2:0] {IDLE, ACCUM, SETTLE, DRAIN, CLEAR} state_t;

  state_t             state;
  logic [pass_bw-1:0] pass_cnt;
  logic [pass_bw-1:0] num_pass_q;
  logic [col-1:0]     seen;
  logic               pass_done;

  // A pass closes once every column has delivered, counting this cycle's beats.
  assign pass_done = (state == ACCUM) && (&(seen | mac_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pass_cnt   <= '0;
      num_pass_q <= '0;
      seen       <= '0;
      relu_en    <= 1'b0;
      lrelu_en   <= 1'b0;
      shift      <= 2'b00;
      dup_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_pass_q <= (num_pass == '0) ? pass_bw'(1) : num_pass;
            relu_en    <= (act_mode == 2'b01) || (act_mode == 2'b10);
            lrelu_en   <= (act_mode == 2'b10);
            shift      <= act_shift;
            dup_err    <= 1'b0;
            pass_cnt   <= '0;
            seen       <= '0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (|(mac_valid & seen)) dup_err <= 1'b1;
          if (pass_done) begin
            seen <= '0;
            if (pass_cnt == num_pass_q - pass_bw'(1)) state <= SETTLE;
            else pass_cnt <= pass_cnt + pass_bw'(1);
          end else begin
            seen <= seen | mac_valid;
          end
        end
        SETTLE: state <= DRAIN;
        DRAIN: begin
          if (!ofifo_full) state <= CLEAR;
        end
        CLEAR: begin
          pass_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Duplicate beats within a pass never reach the accumulators.
  assign sfp_valid_in = (state == ACCUM) ? (mac_valid & ~seen) : '0;
  assign ofifo_wr     = ((state == DRAIN) && !ofifo_full) ? {col{1'b1}} : '0;
  assign acc_clr      = (state == CLEAR);
  assign done         = (state == CLEAR);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sfp_ctrl.sv
// Self-checking bench for sfp_ctrl: directed and randomized operations compared
// against a per-column beat-count model of the accumulation passes.
module tb_sfp_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num_pass = '0;
  logic [1:0] act_mode = '0;
  logic [1:0] act_shift = '0;
  logic [7:0] mac_valid = '0;
  logic       ofifo_full = 1'b0;
  logic [7:0] sfp_valid_in, ofifo_wr;
  logic       acc_clr, relu_en, lrelu_en, busy, done, dup_err;
  logic [1:0] shift;

  int checks = 0;
  int errors = 0;

  logic       exp_relu = 1'b0;
  logic       exp_lrelu = 1'b0;
  logic [1:0] exp_shift = 2'b00;
  logic       exp_dup = 1'b0;

  sfp_ctrl #(.col(8), .pass_bw(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pass(num_pass),
    .act_mode(act_mode), .act_shift(act_shift), .mac_valid(mac_valid),
    .ofifo_full(ofifo_full), .sfp_valid_in(sfp_valid_in), .acc_clr(acc_clr),
    .ofifo_wr(ofifo_wr), .relu_en(relu_en), .lrelu_en(lrelu_en),
    .shift(shift), .busy(busy), .done(done), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the edge, then let them settle.
  task automatic applyStimulus(input logic rst, input logic st, input logic [3:0] np,
                               input logic [1:0] am, input logic [1:0] ash,
                               input logic [7:0] mv, input logic full);
    @(posedge clk);
    #1;
    reset = rst; start = st; num_pass = np; act_mode = am;
    act_shift = ash; mac_valid = mv; ofifo_full = full;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] e_sfp, input logic [7:0] e_wr,
                             input logic e_clr, input logic e_done, input logic e_busy);
    chk({tag, ".sfp_valid_in"}, sfp_valid_in, e_sfp);
    chk({tag, ".ofifo_wr"}, ofifo_wr, e_wr);
    chk({tag, ".acc_clr"}, acc_clr, e_clr);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".relu_en"}, relu_en, exp_relu);
    chk({tag, ".lrelu_en"}, lrelu_en, exp_lrelu);
    chk({tag, ".shift"}, shift, exp_shift);
    chk({tag, ".dup_err"}, dup_err, exp_dup);
  endtask

  // mode 0: all columns every cycle; 1: random, no duplicates; 2: random with
  // duplicates; 3: low half, gap, high half; 4: column 2 twice before column 7.
  task automatic run_op(input logic [3:0] np, input logic [1:0] am, input logic [1:0] ash,
                        input int mode, input int full_cycles);
    int n, p, step, t;
    int beats[8];
    logic [7:0] mv, missing, exp_sfp;
    logic complete;
    n = (np == 0) ? 1 : int'(np);
    applyStimulus(1'b0, 1'b1, np, am, ash, 8'($urandom), 1'b0);
    checkOutput("start", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_relu = (am == 2'b01) || (am == 2'b10);
    exp_lrelu = (am == 2'b10);
    exp_shift = ash;
    exp_dup = 1'b0;
    for (int c = 0; c < 8; c++) beats[c] = 0;
    p = 0; step = 0; t = 0;
    while (p < n && t < 400) begin
      for (int c = 0; c < 8; c++) missing[c] = (beats[c] == p);
      case (mode)
        0: mv = 8'hFF;
        1: mv = 8'($urandom) & missing;
        2: mv = 8'($urandom);
        3: mv = (step % 3 == 0) ? 8'h0F : (step % 3 == 1) ? 8'h00 : 8'hF0;
        default: mv = (step % 4 < 2) ? 8'h04 : (step % 4 == 2) ? 8'h7B : 8'h80;
      endcase
      exp_sfp = mv & missing;
      applyStimulus(1'b0, 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom), mv, 1'($urandom));
      checkOutput("accum", exp_sfp, 8'h00, 1'b0, 1'b0, 1'b1);
      if (|(mv & ~missing)) exp_dup = 1'b1;
      for (int c = 0; c < 8; c++) if (mv[c] && beats[c] == p) beats[c]++;
      complete = 1'b1;
      for (int c = 0; c < 8; c++) if (beats[c] != p + 1) complete = 1'b0;
      step++; t++;
      if (complete) begin p++; step = 0; end
    end
    if (p < n) chk("accum_timeout", 32'(p), 32'(n));
    applyStimulus(1'b0, 1'b1, 4'd1, 2'($urandom), 2'($urandom), 8'hFF, 1'b0);
    checkOutput("settle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < full_cycles; k++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'($urandom), 1'b1);
      checkOutput("drain_full", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'($urandom), 1'b0);
    checkOutput("drain_wr", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd2, 2'($urandom), 2'($urandom), 8'hFF, 1'($urandom));
    checkOutput("clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'($urandom), 1'($urandom));
    checkOutput("idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 4'd0, 2'b00, 2'b00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'hFF, 1'b0);
    checkOutput("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] directed operations");
    run_op(4'd3, 2'b00, 2'd0, 0, 0);
    run_op(4'd2, 2'b01, 2'd1, 3, 0);
    run_op(4'd1, 2'b00, 2'd0, 4, 0);
    run_op(4'd2, 2'b10, 2'd2, 1, 4);

    $display("[TB] reset during accumulation");
    applyStimulus(1'b0, 1'b1, 4'd3, 2'b10, 2'd3, 8'h00, 1'b0);
    checkOutput("rst_start", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_relu = 1'b1; exp_lrelu = 1'b1; exp_shift = 2'd3; exp_dup = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'hFF, 1'b0);
    checkOutput("rst_pass1", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'h04, 1'b0);
    checkOutput("rst_col2", 8'h04, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'h04, 1'b0);
    checkOutput("rst_dup", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    exp_dup = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd0, 2'b00, 2'b00, 8'hFF, 1'b0);
    checkOutput("rst_cycle", 8'hFB, 8'h00, 1'b0, 1'b0, 1'b1);
    exp_relu = 1'b0; exp_lrelu = 1'b0; exp_shift = 2'd0; exp_dup = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 8'hFF, 1'b0);
    checkOutput("post_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(4'd0, 2'b01, 2'd1, 0, 0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 8; i++)
      run_op(4'($urandom_range(0, 5)), 2'($urandom), 2'($urandom),
             int'($urandom_range(1, 2)), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
